// File: rtl/elelock_ctrl.sv
// Attempt sequencer for the electronic lock: counts digit strobes, gates the unlock window,
// clears the key register on abort/timeout/check and escalates wrong codes into a timed lockout.
module elelock_ctrl #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned ENTRY_TMO   = 16,
    parameter int unsigned LOCKOUT_CYC = 64
) (
    input  logic                            ck,
    input  logic                            reset_n,
    input  logic                            key_stb,
    input  logic                            match,
    input  logic                            lock,
    input  logic                            close,
    output logic                            key_inhibit,
    output logic                            key_clr,
    output logic                            unlock_en,
    output logic                            alarm,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic [1:0]                      state
);

    localparam int unsigned FW      = $clog2(MAX_FAIL + 1);
    localparam int unsigned CW      = $clog2(DIGITS + 1);
    localparam int unsigned TMR_MAX = (ENTRY_TMO > LOCKOUT_CYC) ? ENTRY_TMO : LOCKOUT_CYC;
    localparam int unsigned TW      = $clog2(TMR_MAX);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StEntry   = 2'd1,
        StCheck   = 2'd2,
        StLockout = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic            clr_q, clr_d;
    logic [FW-1:0]   fail_inc;
    logic            stb;

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tmr_q   <= '0;
            fail_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            fail_q  <= fail_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        fail_d   = fail_q;
        clr_d    = 1'b0;
        fail_inc = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
        // The datapath drops a strobe that lands on key_clr, so the count must too.
        stb      = key_stb & ~clr_q;

        case (state_q)
            StIdle: begin
                if (stb && lock) begin
                    state_d = StEntry;
                    cnt_d   = CW'(1);
                    tmr_d   = '0;
                end
            end
            StEntry: begin
                if (close || !lock) begin
                    state_d = StIdle;
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else if (stb) begin
                    cnt_d = cnt_q + CW'(1);
                    tmr_d = '0;
                    if (cnt_q + CW'(1) == CW'(DIGITS)) begin
                        state_d = StCheck;
                    end
                end else if (tmr_q == TW'(ENTRY_TMO - 1)) begin
                    state_d = StIdle;
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StCheck: begin
                clr_d = 1'b1;
                cnt_d = '0;
                if (match) begin
                    state_d = StIdle;
                    fail_d  = '0;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FW'(MAX_FAIL)) begin
                        state_d = StLockout;
                        tmr_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StLockout: begin
                if (tmr_q == TW'(LOCKOUT_CYC - 1)) begin
                    state_d = StIdle;
                    fail_d  = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        key_inhibit = (state_q == StCheck) || (state_q == StLockout);
        unlock_en   = (state_q == StCheck);
        alarm       = (state_q == StLockout);
        key_clr     = clr_q;
        fail_cnt    = fail_q;
        state       = state_q;
    end

endmodule

// File: tb/tb_elelock_ctrl.sv
// Self-checking bench for elelock_ctrl: key_clr pulses are scoreboarded against expected
// cycle, state and fail count; sequencing, lockout length and reset are checked directly.
module tb_elelock_ctrl;

    logic       ck = 1'b0;
    logic       reset_n;
    logic       key_stb, match, lock, close;
    logic       key_inhibit, key_clr, unlock_en, alarm;
    logic [1:0] fail_cnt;
    logic [1:0] state;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        int         fail;
    } clr_exp_t;

    clr_exp_t sb_q[$];

    elelock_ctrl #(
        .DIGITS      (4),
        .MAX_FAIL    (3),
        .ENTRY_TMO   (16),
        .LOCKOUT_CYC (64)
    ) dut (
        .ck          (ck),
        .reset_n     (reset_n),
        .key_stb     (key_stb),
        .match       (match),
        .lock        (lock),
        .close       (close),
        .key_inhibit (key_inhibit),
        .key_clr     (key_clr),
        .unlock_en   (unlock_en),
        .alarm       (alarm),
        .fail_cnt    (fail_cnt),
        .state       (state)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every key_clr pulse must match the oldest outstanding expectation.
    always @(negedge ck) begin
        if (key_clr === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexp_clr", key_clr, 0);
            end else begin
                clr_exp_t e;
                e = sb_q.pop_front();
                check_eq("clr_cyc", cyc, e.cyc);
                check_eq("clr_state", state, e.st);
                check_eq("clr_fail", fail_cnt, e.fail);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic strobe();
        key_stb = 1'b1;
        tick(1);
        key_stb = 1'b0;
    endtask

    // Four strobes 3 cycles apart; returns in the cycle after CHECK (key_clr cycle).
    task automatic attempt(input logic m, input logic [1:0] exp_state, input int exp_fail);
        tick(1);
        match = m;
        for (int d = 0; d < 4; d++) begin
            if (d > 0) tick(2);
            if (d == 3) sb_q.push_back('{cyc: cyc + 2, st: exp_state, fail: exp_fail});
            strobe();
            if (d < 3) check_eq("entry_state", state, 1);
        end
        check_eq("check_state", state, 2);
        check_eq("unlock_en_on", unlock_en, 1);
        check_eq("inhibit_check", key_inhibit, 1);
        tick(1);
        check_eq("post_state", state, exp_state);
        check_eq("unlock_en_off", unlock_en, 0);
        check_eq("post_fail", fail_cnt, exp_fail);
    endtask

    initial begin
        int n;
        int t;
        reset_n = 1'b0;
        key_stb = 1'b0;
        match   = 1'b0;
        lock    = 1'b1;
        close   = 1'b0;
        tick(2);
        check_eq("rst_state", state, 0);
        check_eq("rst_fail", fail_cnt, 0);
        check_eq("rst_clr", key_clr, 0);
        check_eq("rst_alarm", alarm, 0);
        check_eq("rst_inhibit", key_inhibit, 0);
        check_eq("rst_unlock", unlock_en, 0);
        reset_n = 1'b1;
        tick(2);

        // Correct code, then a strobe coincident with key_clr must be dropped.
        attempt(1'b1, 2'd0, 0);
        strobe();
        check_eq("clr_drop_state", state, 0);

        // Three wrong codes into lockout; strobes during lockout are ignored.
        attempt(1'b0, 2'd0, 1);
        attempt(1'b0, 2'd0, 2);
        attempt(1'b0, 2'd3, 3);
        check_eq("lock_alarm", alarm, 1);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            key_stb = (i < 60 && i % 5 == 0);
            if (alarm) n++;
            if (i == 30) check_eq("lock_hold", state, 3);
            tick(1);
        end
        key_stb = 1'b0;
        check_eq("alarm_len", n, 64);
        check_eq("after_lock_state", state, 0);
        check_eq("after_lock_fail", fail_cnt, 0);

        // Timeout after two strobes is not a failure.
        attempt(1'b0, 2'd0, 1);
        tick(1);
        strobe();
        tick(1);
        t = cyc;
        sb_q.push_back('{cyc: t + 17, st: 2'd0, fail: 1});
        strobe();
        tick(15);
        check_eq("tmo_pending", state, 1);
        tick(1);
        check_eq("tmo_idle", state, 0);
        check_eq("tmo_fail", fail_cnt, 1);

        // Close coincident with the third strobe aborts without reaching CHECK.
        tick(1);
        strobe();
        tick(1);
        strobe();
        tick(1);
        t = cyc;
        sb_q.push_back('{cyc: t + 1, st: 2'd0, fail: 1});
        close   = 1'b1;
        key_stb = 1'b1;
        tick(1);
        close   = 1'b0;
        key_stb = 1'b0;
        check_eq("close_state", state, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (state == 2'd2) n++;
            tick(1);
        end
        check_eq("close_no_check", n, 0);
        check_eq("close_fail", fail_cnt, 1);

        // Unlocked: strobes are ignored entirely.
        lock = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            strobe();
            if (state != 2'd0 || key_inhibit) n++;
            tick(1);
        end
        check_eq("unlocked_ignored", n, 0);
        lock = 1'b1;

        // Fresh start: two wrong then correct clears the count.
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        attempt(1'b0, 2'd0, 1);
        attempt(1'b0, 2'd0, 2);
        attempt(1'b1, 2'd0, 0);

        // Asynchronous reset in the middle of lockout.
        attempt(1'b0, 2'd0, 1);
        attempt(1'b0, 2'd0, 2);
        attempt(1'b0, 2'd3, 3);
        tick(5);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_alarm", alarm, 0);
        check_eq("arst_state", state, 0);
        check_eq("arst_fail", fail_cnt, 0);
        check_eq("arst_inhibit", key_inhibit, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check_eq("arst_after", state, 0);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
